// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the decode-stage RAW hazard scoreboard: register file
// geometry, instruction field positions, WISC-SP13 opcodes and default sizes.
package hazard_scoreboard_pkg;

  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;

  localparam int SB_CNT_W    = 2;
  localparam int SB_WB_DEPTH = 3;
  localparam int SB_PERF_W   = 16;

  localparam int RS_HI = 10;
  localparam int RS_LO = 8;
  localparam int RT_HI = 7;
  localparam int RT_LO = 5;

  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;

  function automatic logic [REG_IDX_W-1:0] field_rs(input logic [15:0] instr);
    return instr[RS_HI:RS_LO];
  endfunction

  function automatic logic [REG_IDX_W-1:0] field_rt(input logic [15:0] instr);
    return instr[RT_HI:RT_LO];
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One per-register countdown of cycles until an in-flight write is readable.
// Load has priority over decrement; busy is combinational from the count.
module sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode RAW hazard detector: same-cycle stall from per-register countdowns, no pipeline latency.
// HAZARD_FWD_EN: only loads allocate (1 cycle); otherwise every write allocates WB_DEPTH.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W    = SB_CNT_W,
  parameter int WB_DEPTH = SB_WB_DEPTH,
  parameter int PERF_W   = SB_PERF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  input  logic [15:0]          dec_instr,
  input  logic [1:0]           num_reg_reads,
  input  logic                 dec_wr_en,
  input  logic [REG_IDX_W-1:0] dec_wr_reg,
  input  logic                 dec_is_load,
  input  logic                 flush,
  output logic                 stall,
  output logic [NUM_REGS-1:0]  busy_mask,
  output logic [PERF_W-1:0]    stall_cycles
);

  logic [NUM_REGS-1:0]  busy;
  logic [NUM_REGS-1:0]  wr_sel;
  logic [REG_IDX_W-1:0] src_a;
  logic [REG_IDX_W-1:0] src_b;
  logic                 hz_a;
  logic                 hz_b;
  logic                 issue;
  logic                 alloc;
  logic [CNT_W-1:0]     alloc_val;
  logic [9:0]           unused_instr_bits;

  assign unused_instr_bits = {dec_instr[15:11], dec_instr[4:0]};

  assign src_a = field_rs(dec_instr);
  assign src_b = field_rt(dec_instr);

  // Hazard check reads the counters before this cycle's allocation, so an
  // instruction that sources its own destination only sees the old state.
  assign hz_a  = (num_reg_reads != 2'd0) && busy[src_a];
  assign hz_b  = num_reg_reads[1] && busy[src_b];
  assign stall = dec_valid && !flush && (hz_a || hz_b);
  assign issue = dec_valid && !stall && !flush && dec_wr_en;

`ifdef HAZARD_FWD_EN
  assign alloc     = issue && dec_is_load;
  assign alloc_val = CNT_W'(1);
`else
  logic unused_is_load;
  assign unused_is_load = dec_is_load;
  assign alloc          = issue;
  assign alloc_val      = CNT_W'(WB_DEPTH);
`endif

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = alloc && (dec_wr_reg == REG_IDX_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clk      (clk),
      .rst      (rst),
      .load     (wr_sel[g]),
      .load_val (alloc_val),
      .busy     (busy[g])
    );
  end

  assign busy_mask = busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

endmodule
